// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-port FIFO: pointer sizing and the lane prefix-count function.
package fifo_pkg;

  localparam int unsigned MAX_PORTS = 4;

  // Pointer width including the wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Number of consecutive ones starting at bit 0.
  function automatic int unsigned prefix_len(input logic [MAX_PORTS-1:0] vec);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_PORTS; i++) begin
      run = run & vec[i];
      if (run) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_fifo_mp_if.sv
// Handshake bundle for sync_fifo_mp: enqueue lanes, dequeue lanes, flush and status.
interface sync_fifo_mp_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned ENQ_PORTS   = 2,
  parameter int unsigned DEQ_PORTS   = 2
);

  localparam int unsigned CNT_W = ptr_w(QUEUE_DEPTH);

  logic                            flush;
  logic [ENQ_PORTS-1:0]            enq_valid;
  logic [ENQ_PORTS*DATA_WIDTH-1:0] enq_wdata;
  logic [ENQ_PORTS-1:0]            enq_ready;
  logic [DEQ_PORTS-1:0]            deq_ready;
  logic [DEQ_PORTS-1:0]            deq_valid;
  logic [DEQ_PORTS*DATA_WIDTH-1:0] deq_rdata;
  logic [CNT_W-1:0]                count;
  logic                            is_full;
  logic                            is_empty;
  logic                            almost_full;

  modport master (
    output flush, enq_valid, enq_wdata, deq_ready,
    input  enq_ready, deq_valid, deq_rdata, count, is_full, is_empty, almost_full
  );

  modport slave (
    input  flush, enq_valid, enq_wdata, deq_ready,
    output enq_ready, deq_valid, deq_rdata, count, is_full, is_empty, almost_full
  );

endinterface

// File: rtl/fifo_lane_cnt.sv
// Counts the contiguous run of set lanes starting at lane 0.
module fifo_lane_cnt
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CNT_W-1:0] o_cnt
);

  logic [MAX_PORTS-1:0] w_vec;

  always_comb begin
    w_vec            = '0;
    w_vec[WIDTH-1:0] = i_vec;
  end

  assign o_cnt = CNT_W'(prefix_len(w_vec));

endmodule

// File: rtl/sync_fifo_mp.sv
// Multi-port synchronous FWFT FIFO: up to ENQ_PORTS writes and DEQ_PORTS reads per cycle,
// with flush, registered occupancy count and almost-full reporting.
module sync_fifo_mp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned QUEUE_DEPTH  = 16,
  parameter int unsigned ENQ_PORTS    = 2,
  parameter int unsigned DEQ_PORTS    = 2,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_mp_if.slave bus
);

  localparam int unsigned PTR_W  = ptr_w(QUEUE_DEPTH);
  localparam int unsigned IDX_W  = PTR_W - 1;
  localparam int unsigned ENQ_CW = $clog2(ENQ_PORTS + 1);
  localparam int unsigned DEQ_CW = $clog2(DEQ_PORTS + 1);

  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [PTR_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_mem [QUEUE_DEPTH];

  logic [PTR_W-1:0]                w_free;
  logic [ENQ_PORTS-1:0]            w_enq_ready;
  logic [ENQ_PORTS-1:0]            w_enq_fire;
  logic [ENQ_PORTS-1:0]            w_wr_en;
  logic [DEQ_PORTS-1:0]            w_deq_valid;
  logic [DEQ_PORTS-1:0]            w_deq_fire;
  logic [ENQ_CW-1:0]               w_n_enq;
  logic [DEQ_CW-1:0]               w_n_deq;
  logic [IDX_W-1:0]                w_widx [ENQ_PORTS];
  logic [IDX_W-1:0]                w_ridx [DEQ_PORTS];
  logic [DEQ_PORTS*DATA_WIDTH-1:0] w_rdata;
  logic                            w_clear;

  assign w_clear = rst | bus.flush;

  // Readiness uses only pre-cycle free space; a same-cycle dequeue never frees a slot.
  assign w_free = PTR_W'(QUEUE_DEPTH) - r_count;

  always_comb begin
    for (int i = 0; i < ENQ_PORTS; i++) begin
      w_enq_ready[i] = w_free > PTR_W'(i);
      w_widx[i]      = r_wptr[IDX_W-1:0] + IDX_W'(i);
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < DEQ_PORTS; i++) begin
      w_deq_valid[i] = r_count > PTR_W'(i);
      w_ridx[i]      = r_rptr[IDX_W-1:0] + IDX_W'(i);
      if (w_deq_valid[i]) w_rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ridx[i]];
    end
  end

  assign w_enq_fire = bus.enq_valid & w_enq_ready;
  assign w_deq_fire = bus.deq_ready & w_deq_valid;

  fifo_lane_cnt #(
    .WIDTH(ENQ_PORTS)
  ) u_enq_cnt (
    .i_vec(w_enq_fire),
    .o_cnt(w_n_enq)
  );

  fifo_lane_cnt #(
    .WIDTH(DEQ_PORTS)
  ) u_deq_cnt (
    .i_vec(w_deq_fire),
    .o_cnt(w_n_deq)
  );

  // Lanes past the first gap are dropped even if they are valid and ready.
  always_comb begin
    for (int k = 0; k < ENQ_PORTS; k++) begin
      w_wr_en[k] = ENQ_CW'(k) < w_n_enq;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_clear) begin
      for (int k = 0; k < ENQ_PORTS; k++) begin
        if (w_wr_en[k]) r_mem[w_widx[k]] <= bus.enq_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_n_enq);
      r_rptr  <= r_rptr + PTR_W'(w_n_deq);
      r_count <= r_count + PTR_W'(w_n_enq) - PTR_W'(w_n_deq);
    end
  end

  assign bus.enq_ready   = w_enq_ready;
  assign bus.deq_valid   = w_deq_valid;
  assign bus.deq_rdata   = w_rdata;
  assign bus.count       = r_count;
  assign bus.is_full     = r_count == PTR_W'(QUEUE_DEPTH);
  assign bus.is_empty    = r_count == '0;
  assign bus.almost_full = 32'(w_free) <= AFULL_MARGIN;

endmodule

// File: tb/tb_sync_fifo_mp.sv
// Directed and random bench for sync_fifo_mp against a queue-based reference model.
module tb_sync_fifo_mp;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned MARG  = 2;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic [DW-1:0] mq[$];

  sync_fifo_mp_if #(
    .DATA_WIDTH (DW),
    .QUEUE_DEPTH(DEPTH),
    .ENQ_PORTS  (2),
    .DEQ_PORTS  (2)
  ) bus ();

  sync_fifo_mp #(
    .DATA_WIDTH  (DW),
    .QUEUE_DEPTH (DEPTH),
    .ENQ_PORTS   (2),
    .DEQ_PORTS   (2),
    .AFULL_MARGIN(MARG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int            sz;
    int            free;
    logic [1:0]    e_rdy;
    logic [1:0]    e_vld;
    logic [127:0]  e_data;
    sz     = mq.size();
    free   = DEPTH - sz;
    e_rdy  = {free > 1, free > 0};
    e_vld  = {sz > 1, sz > 0};
    e_data = '0;
    if (sz > 0) e_data[63:0] = mq[0];
    if (sz > 1) e_data[127:64] = mq[1];
    chk("count", 128'(bus.count), 128'(sz));
    chk("is_full", 128'(bus.is_full), 128'(sz == DEPTH));
    chk("is_empty", 128'(bus.is_empty), 128'(sz == 0));
    chk("almost_full", 128'(bus.almost_full), 128'(free <= MARG));
    chk("enq_ready", 128'(bus.enq_ready), 128'(e_rdy));
    chk("deq_valid", 128'(bus.deq_valid), 128'(e_vld));
    chk("deq_rdata", bus.deq_rdata, e_data);
  endtask

  // One clock: drive inputs, check pre-edge outputs, then advance the model across the edge.
  task automatic step(input logic [1:0] ev, input logic [127:0] wd, input logic [1:0] dr,
                      input logic fl, input logic rs);
    int sz;
    int n_enq;
    int n_deq;
    @(negedge clk);
    bus.enq_valid = ev;
    bus.enq_wdata = wd;
    bus.deq_ready = dr;
    bus.flush     = fl;
    rst           = rs;
    #1;
    check_outputs();
    sz    = mq.size();
    n_enq = 0;
    for (int i = 0; i < 2; i++) begin
      if (n_enq == i && ev[i] && (DEPTH - sz) > i) n_enq++;
    end
    n_deq = 0;
    for (int i = 0; i < 2; i++) begin
      if (n_deq == i && dr[i] && sz > i) n_deq++;
    end
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
    end else begin
      repeat (n_deq) void'(mq.pop_front());
      for (int k = 0; k < n_enq; k++) mq.push_back(wd[k*64 +: 64]);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] va;
    logic [63:0] vb;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.enq_valid = '0;
    bus.enq_wdata = '0;
    bus.deq_ready = '0;
    repeat (2) @(posedge clk);

    // Reset state, then dual enqueue and single dequeue.
    va = 64'hAAAA_0000_0000_000A;
    vb = 64'hBBBB_0000_0000_000B;
    step(2'b00, '0, 2'b00, 1'b0, 1'b0);
    step(2'b11, {vb, va}, 2'b00, 1'b0, 1'b0);
    step(2'b00, '0, 2'b01, 1'b0, 1'b0);
    step(2'b00, '0, 2'b00, 1'b0, 1'b0);

    // Fill to 15, then only lane 0 fits.
    repeat (7) step(2'b11, {rnd64(), rnd64()}, 2'b00, 1'b0, 1'b0);
    step(2'b11, {rnd64(), rnd64()}, 2'b00, 1'b0, 1'b0);
    step(2'b00, '0, 2'b00, 1'b0, 1'b0);
    // Full with dual dequeue: no write that cycle.
    step(2'b11, {rnd64(), rnd64()}, 2'b11, 1'b0, 1'b0);
    step(2'b00, '0, 2'b00, 1'b0, 1'b0);

    // Lane 1 alone is not contiguous from lane 0.
    step(2'b10, {rnd64(), rnd64()}, 2'b00, 1'b0, 1'b0);
    step(2'b00, '0, 2'b00, 1'b0, 1'b0);

    // Drain, walk the write index to 15, then straddle the wrap.
    repeat (7) step(2'b00, '0, 2'b11, 1'b0, 1'b0);
    repeat (14) step(2'b01, {64'h0, rnd64()}, 2'b01, 1'b0, 1'b0);
    step(2'b00, '0, 2'b01, 1'b0, 1'b0);
    va = 64'hCCCC_0000_0000_000C;
    vb = 64'hDDDD_0000_0000_000D;
    step(2'b11, {vb, va}, 2'b00, 1'b0, 1'b0);
    step(2'b00, '0, 2'b11, 1'b0, 1'b0);
    step(2'b00, '0, 2'b00, 1'b0, 1'b0);

    // Flush at count 7 overrides enqueue and dequeue.
    repeat (3) step(2'b11, {rnd64(), rnd64()}, 2'b00, 1'b0, 1'b0);
    step(2'b01, {64'h0, rnd64()}, 2'b00, 1'b0, 1'b0);
    step(2'b11, {rnd64(), rnd64()}, 2'b11, 1'b1, 1'b0);
    va = 64'hEEEE_0000_0000_000E;
    step(2'b01, {64'h0, va}, 2'b00, 1'b0, 1'b0);
    step(2'b00, '0, 2'b00, 1'b0, 1'b0);

    // Random traffic with occasional flush and mid-run reset.
    for (int c = 0; c < 400; c++) begin
      step(2'($urandom_range(0, 3)), {rnd64(), rnd64()}, 2'($urandom_range(0, 3)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end
    step(2'b00, '0, 2'b00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
